mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port unified memory between two requesters: the fetch stage (instruction reads) and the MEM stage (data reads/writes).
- Sits between the pipelined datapath and the memory model.
- Sequences each access through a small FSM and raises per-port ready pulses. The pipeline derives its stalls from these pulses.
- Accesses are serialized: exactly one transaction is outstanding at a time.

Parameters:
N, 64, data/address width
LAT, 2, memory wait cycles per access (legal range 1..15)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch read request, held until if_ready
if_addr  input  N  fetch byte address
if_rdata  output  32  fetched instruction word
if_ready  output  1  one-cycle pulse: fetch transaction complete
dm_readEnable  input  1  data read request, held until dm_ready
dm_writeEnable  input  1  data write request, held until dm_ready
dm_addr  input  N  data byte address
dm_writeData  input  N  write data
dm_rdata  output  N  data read result
dm_ready  output  1  one-cycle pulse: data transaction complete
mem_en  output  1  memory access enable
mem_we  output  1  memory write enable
mem_addr  output  N  memory address
mem_wdata  output  N  memory write data
mem_rdata  input  N  memory read data, valid when LAT cycles of mem_en have elapsed
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (synchronous, active-high) is the only reset. Every output resets to 0. FSM goes to IDLE, wait counter to 0, last_grant to IF.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any request is pending, arbitrate and latch into internal registers: grantee, addr, wdata, we. Load the wait counter with LAT-1. Go to ACCESS.
  - If no request is pending, stay in IDLE with mem_en=0.
- ACCESS:
  - mem_en=1. mem_addr, mem_we and mem_wdata are driven from the latched registers, so they are stable for the whole access.
  - The counter decrements each cycle.
  - When the counter reaches 0:
    - Read: capture mem_rdata into the grantee's rdata register.
    - Go to DONE.
- DONE:
  - mem_en=0. The grantee's ready is 1 for exactly this one cycle.
  - Requests are ignored in DONE, so the still-held request is not re-granted.
  - Next state is IDLE.
- Latency: request first seen in IDLE at cycle t -> ready high at cycle t+LAT+1. Back-to-back transactions have a throughput of one access per LAT+2 cycles.
- Arbitration (default): fixed data priority. dm wins over if_req on contention.
- dm request = dm_readEnable | dm_writeEnable. If both are asserted, the access is a write (mem_we=1).
- Fetch width select: if_rdata = if_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0], using the latched address. Fetch never writes.
- Output holding:
  - if_rdata and dm_rdata hold their last captured value until the next read completes on that port.
  - A data write leaves dm_rdata unchanged.
- Requester drops its request mid-ACCESS: the transaction still completes and ready still pulses. Transactions are not cancellable.
- Reset asserted in any state: back to IDLE next cycle with mem_en=0. No ready pulse is produced and the in-flight access is discarded.
- last_grant updates on every grant.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. On contention, grant the requester that is not last_grant. With no contention, grant whichever requester is pending. last_grant resets to IF, so the first contention goes to dm.
- Undefined: fixed data priority as above. last_grant is still maintained but does not affect the grant.

Test Plan:
- LAT=2, reset, then if_req=1 with if_addr=0x4 and mem_rdata=0xAAAA_BBBB_CCCC_DDDD -> mem_en high 2 cycles, if_ready at t+3, if_rdata=0xAAAABBBB, busy high 3 cycles.
- dm_writeEnable=1, dm_addr=0x18, dm_writeData=0x1234 -> mem_we=1, mem_addr=0x18, mem_wdata=0x1234 for 2 cycles, dm_ready pulse, dm_rdata unchanged.
- if_req and dm_readEnable asserted together and held, default build -> dm served first (dm_ready at t+3), then if served (if_ready at t+7). No double grant in the DONE cycles.
- Same stimulus with MEM_ARB_RR_EN defined and both held continuously -> grant order dm, if, dm, if; ready pulses alternate every 4 cycles.
- reset asserted in the 2nd ACCESS cycle of a data read -> next cycle mem_en=0, busy=0, no dm_ready, dm_rdata=0.
- dm_readEnable and dm_writeEnable both high -> treated as write (mem_we=1); LAT=1 build gives ready at t+2.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port memory between instruction fetch and data access.
// Optional MEM_ARB_RR_EN: round-robin arbitration instead of fixed data priority.
module mem_arbiter #(
    parameter int N   = 64,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         if_req,
    input  logic [N-1:0] if_addr,
    output logic [31:0]  if_rdata,
    output logic         if_ready,
    input  logic         dm_readEnable,
    input  logic         dm_writeEnable,
    input  logic [N-1:0] dm_addr,
    input  logic [N-1:0] dm_writeData,
    output logic [N-1:0] dm_rdata,
    output logic         dm_ready,
    output logic         mem_en,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,
    output logic         busy
);

    // state  | meaning
    // IDLE   | waiting for a request; arbitration happens here
    // ACCESS | memory enabled, wait counter running down
    // DONE   | ready pulse to the grantee; held requests ignored
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       last_grant;   // 0 = fetch, 1 = data
    logic       grant_dm;
    logic       dm_req;
    logic       pick_dm;

    always_comb begin
        dm_req = dm_readEnable | dm_writeEnable;
`ifdef MEM_ARB_RR_EN
        pick_dm = dm_req & (~if_req | ~last_grant);
`else
        pick_dm = dm_req;
`endif
    end

    // mem_addr/mem_wdata double as the latched transaction registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b0;
            grant_dm   <= 1'b0;
            if_rdata   <= '0;
            if_ready   <= 1'b0;
            dm_rdata   <= '0;
            dm_ready   <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dm_req || if_req) begin
                        grant_dm   <= pick_dm;
                        last_grant <= pick_dm;
                        mem_addr   <= pick_dm ? dm_addr : if_addr;
                        mem_wdata  <= pick_dm ? dm_writeData : '0;
                        mem_we     <= pick_dm & dm_writeEnable;
                        mem_en     <= 1'b1;
                        busy       <= 1'b1;
                        cnt        <= 4'(LAT - 1);
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (!mem_we) begin
                            if (grant_dm)
                                dm_rdata <= mem_rdata;
                            else
                                if_rdata <= mem_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                        end
                        mem_en   <= 1'b0;
                        mem_we   <= 1'b0;
                        if_ready <= ~grant_dm;
                        dm_ready <= grant_dm;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if_ready <= 1'b0;
                    dm_ready <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table plus contention, reset-abort and LAT=1 sequences,
// checked through a scoreboard of expected grants against a small memory model.
module tb_mem_arbiter;
    localparam int N   = 64;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         if_req;
    logic [N-1:0] if_addr;
    logic [31:0]  if_rdata;
    logic         if_ready;
    logic         dm_readEnable, dm_writeEnable;
    logic [N-1:0] dm_addr, dm_writeData, dm_rdata;
    logic         dm_ready;
    logic         mem_en, mem_we;
    logic [N-1:0] mem_addr, mem_wdata, mem_rdata;
    logic         busy;

    logic         l1_if_req, l1_if_ready, l1_rd, l1_wr, l1_dm_ready;
    logic         l1_mem_en, l1_mem_we, l1_busy;
    logic [31:0]  l1_if_rdata;
    logic [N-1:0] l1_if_addr, l1_dm_addr, l1_dm_wdata, l1_dm_rdata;
    logic [N-1:0] l1_mem_addr, l1_mem_wdata, l1_mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.N(N), .LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_readEnable(dm_readEnable), .dm_writeEnable(dm_writeEnable),
        .dm_addr(dm_addr), .dm_writeData(dm_writeData), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.N(N), .LAT(1)) dut_l1 (
        .clk(clk), .reset(reset),
        .if_req(l1_if_req), .if_addr(l1_if_addr), .if_rdata(l1_if_rdata), .if_ready(l1_if_ready),
        .dm_readEnable(l1_rd), .dm_writeEnable(l1_wr),
        .dm_addr(l1_dm_addr), .dm_writeData(l1_dm_wdata), .dm_rdata(l1_dm_rdata), .dm_ready(l1_dm_ready),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
        .mem_rdata(l1_mem_rdata), .busy(l1_busy)
    );

    typedef struct {
        logic        is_dm;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] data;
    } sb_t;

    typedef struct {
        int          kind;     // 0 fetch, 1 dm read, 2 dm write, 3 dm read+write
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        exp_we;
    } vec_t;

    sb_t         sb[$];
    logic [63:0] mem_arr[16];
    logic [63:0] shadow[16];
    logic [63:0] exp_dm;
    int          total = 0;
    int          bad = 0;
    int          en_cnt = 0;

    assign mem_rdata = mem_arr[mem_addr[6:3]];

    function automatic logic [63:0] init_val(input int i);
        logic [63:0] v;
        if (i == 0) v = 64'hAAAA_BBBB_CCCC_DDDD;
        else        v = {32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i)};
        return v;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push_exp(input logic is_dm, input logic we,
                                     input logic [63:0] addr, input logic [63:0] wdata);
        sb_t         e;
        logic [63:0] w;
        e.is_dm = is_dm; e.we = we; e.addr = addr; e.wdata = wdata;
        w = shadow[addr[6:3]];
        if (!is_dm) begin
            e.data = addr[2] ? {32'b0, w[63:32]} : {32'b0, w[31:0]};
        end else if (we) begin
            e.data = exp_dm;
            shadow[addr[6:3]] = wdata;
        end else begin
            e.data = w;
            exp_dm = w;
        end
        sb.push_back(e);
    endfunction

    // monitor: memory model writes, bus checks against the scoreboard head, ready pops
    initial begin
        sb_t e;
        for (int i = 0; i < 16; i++) mem_arr[i] = init_val(i);
        forever begin
            @(negedge clk);
            if (!busy) en_cnt = 0;
            if (mem_en) begin
                en_cnt++;
                if (sb.size() == 0) chk("unexpected_grant", 1, 0);
                else begin
                    chk("mem_addr", mem_addr, sb[0].addr);
                    chk("mem_we", 64'(mem_we), 64'(sb[0].we));
                    if (sb[0].we) begin
                        chk("mem_wdata", mem_wdata, sb[0].wdata);
                        mem_arr[mem_addr[6:3]] = mem_wdata;
                    end
                end
            end
            if (if_ready || dm_ready) begin
                if (sb.size() == 0) chk("spurious_ready", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("ready_port", 64'(dm_ready), 64'(e.is_dm));
                    chk("both_ready", 64'(if_ready & dm_ready), 0);
                    chk("en_cycles", 64'(en_cnt), 64'(LAT));
                    if (e.is_dm) chk("dm_rdata", dm_rdata, e.data);
                    else         chk("if_rdata", 64'(if_rdata), e.data);
                end
            end
        end
    end

    task automatic run_txn(input vec_t v);
        int   lat;
        logic got;
        @(negedge clk);
        if (v.kind == 0) begin if_req = 1'b1; if_addr = v.addr; end
        else begin
            dm_readEnable  = (v.kind == 1 || v.kind == 3);
            dm_writeEnable = (v.kind == 2 || v.kind == 3);
            dm_addr = v.addr; dm_writeData = v.wdata;
        end
        push_exp(v.kind != 0, v.exp_we, v.addr, v.wdata);
        lat = 0; got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            lat++;
            if ((v.kind == 0) ? if_ready : dm_ready) got = 1'b1;
        end
        chk("txn_timeout", 64'(got), 1);
        chk("txn_latency", 64'(lat), 64'(LAT + 1));
        if_req = 1'b0; dm_readEnable = 1'b0; dm_writeEnable = 1'b0;
    endtask

    initial begin
        vec_t vecs[8];
        int   t_dm, t_if, n, lat;
        int   rt[4];
        logic rp[4];
        logic saw_we;

        vecs[0] = '{0, 64'h04, 64'h0, 1'b0};
        vecs[1] = '{2, 64'h18, 64'h1234, 1'b1};
        vecs[2] = '{1, 64'h18, 64'h0, 1'b0};
        vecs[3] = '{0, 64'h18, 64'h0, 1'b0};
        vecs[4] = '{3, 64'h20, 64'hDEAD_BEEF_0BAD_F00D, 1'b1};
        vecs[5] = '{0, 64'h24, 64'h0, 1'b0};
        vecs[6] = '{1, 64'h08, 64'h0, 1'b0};
        vecs[7] = '{0, 64'h00, 64'h0, 1'b0};

        for (int i = 0; i < 16; i++) shadow[i] = init_val(i);
        exp_dm = '0;
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_readEnable = 1'b0; dm_writeEnable = 1'b0; dm_addr = '0; dm_writeData = '0;
        l1_if_req = 1'b0; l1_if_addr = '0; l1_rd = 1'b0; l1_wr = 1'b0;
        l1_dm_addr = '0; l1_dm_wdata = '0; l1_mem_rdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_mem_en", 64'(mem_en), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_ready", 64'({if_ready, dm_ready}), 0);
        chk("rst_rdata", dm_rdata | 64'(if_rdata), 0);
        chk("rst_bus", mem_addr | mem_wdata | 64'(mem_we), 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // reset during the 2nd ACCESS cycle of a data read
        @(negedge clk);
        dm_readEnable = 1'b1; dm_addr = 64'h08;
        push_exp(1'b1, 1'b0, 64'h08, 64'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; dm_readEnable = 1'b0;
        @(negedge clk);
        chk("abort_mem_en", 64'(mem_en), 0);
        chk("abort_busy", 64'(busy), 0);
        chk("abort_ready", 64'(dm_ready), 0);
        chk("abort_rdata", dm_rdata, 0);
        void'(sb.pop_front());
        exp_dm = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // contention, dm released after its ready
        dm_readEnable = 1'b1; dm_addr = 64'h10;
        if_req = 1'b1; if_addr = 64'h0C;
        push_exp(1'b1, 1'b0, 64'h10, 64'h0);
        push_exp(1'b0, 1'b0, 64'h0C, 64'h0);
        t_dm = -1; t_if = -1;
        for (int c = 1; c <= 30 && t_if < 0; c++) begin
            @(negedge clk);
            if (dm_ready) begin t_dm = c; dm_readEnable = 1'b0; end
            if (if_ready) begin t_if = c; if_req = 1'b0; end
        end
        chk("cont_dm_time", 64'(t_dm), 64'(LAT + 1));
        chk("cont_if_time", 64'(t_if), 64'(2 * LAT + 3));
        if_req = 1'b0; dm_readEnable = 1'b0;

`ifdef MEM_ARB_RR_EN
        // both held continuously: grants alternate dm, if, dm, if
        @(negedge clk);
        dm_readEnable = 1'b1; dm_addr = 64'h28;
        if_req = 1'b1; if_addr = 64'h30;
        for (int k = 0; k < 2; k++) begin
            push_exp(1'b1, 1'b0, 64'h28, 64'h0);
            push_exp(1'b0, 1'b0, 64'h30, 64'h0);
        end
        n = 0;
        for (int c = 1; c <= 60 && n < 4; c++) begin
            @(negedge clk);
            if (if_ready || dm_ready) begin rt[n] = c; rp[n] = dm_ready; n++; end
        end
        if_req = 1'b0; dm_readEnable = 1'b0;
        chk("rr_count", 64'(n), 4);
        for (int k = 0; k < n; k++) begin
            chk("rr_time", 64'(rt[k]), 64'(k * (LAT + 2) + LAT + 1));
            chk("rr_port", 64'(rp[k]), 64'(k % 2 == 0));
        end
`endif

        // LAT=1 instance: read+write together is a write, ready at t+2
        @(negedge clk);
        l1_rd = 1'b1; l1_wr = 1'b1; l1_dm_addr = 64'h20; l1_dm_wdata = 64'h55;
        lat = 0; saw_we = 1'b0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            if (l1_mem_en && l1_mem_we) saw_we = 1'b1;
            if (l1_dm_ready) lat = c;
        end
        l1_rd = 1'b0; l1_wr = 1'b0;
        chk("l1_latency", 64'(lat), 2);
        chk("l1_we", 64'(saw_we), 1);
        chk("l1_rdata", l1_dm_rdata, 0);

        repeat (4) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
